shift_rows: RTL and testbench



---
 rtl/shift_rows_pkg.sv | 15 +
 rtl/ShiftRows.sv | 24 ++
 rtl/ShiftRowsInverse.sv | 24 ++
 rtl/shift_rows_perm.sv | 22 ++
 rtl/shift_rows.sv | 47 ++++
 tb/tb_shift_rows.sv | 171 +++++++++++++++++
 6 files changed

// File: rtl/shift_rows_pkg.sv
// Shared AES state types, geometry constants and the byte-index helper.
package shift_rows_pkg;

    typedef logic [127:0] state_t;
    typedef logic [7:0]   byte_t;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;

    // Column-major: byte k holds s[k%4][k/4], byte 0 is the MSB byte.
    function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
        return r + NUM_ROWS * c;
    endfunction

endpackage

// File: rtl/ShiftRows.sv
// Forward ShiftRows stage for the encrypt round pipeline.
module ShiftRows
    import shift_rows_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   valid_in,
    input  state_t in,
    output logic   valid_out,
    output state_t out
);

    shift_rows #(
        .INVERSE(1'b0)
    ) u_shift_rows (
        .clock    (clock),
        .reset_n  (reset_n),
        .valid_in (valid_in),
        .in       (in),
        .valid_out(valid_out),
        .out      (out)
    );

endmodule

// File: rtl/ShiftRowsInverse.sv
// InvShiftRows stage for the decrypt round pipeline.
module ShiftRowsInverse
    import shift_rows_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   valid_in,
    input  state_t in,
    output logic   valid_out,
    output state_t out
);

    shift_rows #(
        .INVERSE(1'b1)
    ) u_shift_rows (
        .clock    (clock),
        .reset_n  (reset_n),
        .valid_in (valid_in),
        .in       (in),
        .valid_out(valid_out),
        .out      (out)
    );

endmodule

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation; pure wiring.
module shift_rows_perm
    import shift_rows_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  state_t in,
    output state_t perm
);

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            // Forward rotates row r left by r; inverse rotates it right by r.
            localparam int unsigned SrcCol = INVERSE ? (c + NUM_COLS - r) % NUM_COLS
                                                     : (c + r) % NUM_COLS;
            localparam int unsigned Dst = byte_idx(r, c);
            localparam int unsigned Src = byte_idx(r, SrcCol);
            assign perm[127-8*Dst -: 8] = in[127-8*Src -: 8];
        end
    end

endmodule

// File: rtl/shift_rows.sv
// AES ShiftRows stage: byte permutation followed by one registered output with valid.
module shift_rows
    import shift_rows_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   valid_in,
    input  state_t in,
    output logic   valid_out,
    output state_t out
);

    state_t perm_w;
    state_t out_d, out_q;
    logic   valid_q;

    shift_rows_perm #(
        .INVERSE(INVERSE)
    ) u_perm (
        .in  (in),
        .perm(perm_w)
    );

    // Only a sampled-high valid_in loads the register, so X on idle inputs never reaches out.
    always_comb begin
        out_d = out_q;
        if (valid_in) begin
            out_d = perm_w;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_in;
        end
    end

    assign out       = out_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_shift_rows.sv
// Directed bench for shift_rows: FIPS-197 vectors, index patterns, hold, reset, round trip.
module tb_shift_rows;

    localparam logic [127:0] AppBIn   = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] AppBOut  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] IdxIn    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] IdxFwd   = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] IdxInv   = 128'h000d0a0704010e0b0805020f0c090603;

    logic         clock;
    logic         reset_n;
    logic         f_vin, f_vout, w_vout, i_vin, i_vout, tb_i_vin, use_chain;
    logic [127:0] f_in, f_out, w_out, i_in, i_out, tb_i_in;

    int n_cmp = 0;
    int n_err = 0;

    shift_rows #(
        .INVERSE(1'b0)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .valid_in (f_vin),
        .in       (f_in),
        .valid_out(f_vout),
        .out      (f_out)
    );

    ShiftRows u_fwd_wrap (
        .clock    (clock),
        .reset_n  (reset_n),
        .valid_in (f_vin),
        .in       (f_in),
        .valid_out(w_vout),
        .out      (w_out)
    );

    assign i_in  = use_chain ? f_out : tb_i_in;
    assign i_vin = use_chain ? f_vout : tb_i_vin;

    ShiftRowsInverse u_inv (
        .clock    (clock),
        .reset_n  (reset_n),
        .valid_in (i_vin),
        .in       (i_in),
        .valid_out(i_vout),
        .out      (i_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [127:0] x, x_prev;
        logic         v, v_prev;

        reset_n   = 1'b1;
        f_vin     = 1'b0;
        f_in      = '0;
        tb_i_vin  = 1'b0;
        tb_i_in   = '0;
        use_chain = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("reset_out", f_out, '0);
        check("reset_valid", {127'd0, f_vout}, 128'd0);
        check("reset_inv_out", i_out, '0);
        check("reset_inv_valid", {127'd0, i_vout}, 128'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // FIPS-197 App. B forward, both through shift_rows and the wrapper
        f_vin = 1'b1;
        f_in  = AppBIn;
        step();
        check("appb_fwd", f_out, AppBOut);
        check("appb_fwd_valid", {127'd0, f_vout}, 128'd1);
        check("appb_wrap", w_out, AppBOut);

        // Idle with X on the data bus: out holds, valid drops
        f_vin = 1'b0;
        f_in  = 'x;
        step();
        check("hold_out", f_out, AppBOut);
        check("hold_valid", {127'd0, f_vout}, 128'd0);
        step();
        check("hold_out2", f_out, AppBOut);

        f_vin = 1'b1;
        f_in  = IdxIn;
        step();
        check("idx_fwd", f_out, IdxFwd);
        check("idx_wrap", w_out, IdxFwd);
        f_vin = 1'b0;

        tb_i_vin = 1'b1;
        tb_i_in  = AppBOut;
        step();
        check("appb_inv", i_out, AppBIn);
        check("appb_inv_valid", {127'd0, i_vout}, 128'd1);
        tb_i_in = IdxIn;
        step();
        check("idx_inv", i_out, IdxInv);
        tb_i_vin = 1'b0;
        step();
        check("inv_hold_valid", {127'd0, i_vout}, 128'd0);
        check("inv_hold_out", i_out, IdxInv);

        // Round trip: forward feeds inverse, random states nearly every cycle
        use_chain = 1'b1;
        f_vin = 1'b0;
        step();
        x_prev = '0;
        v_prev = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            v = ($urandom_range(0, 7) != 0);
            f_in  = x;
            f_vin = v;
            step();
            check("rt_fwd_valid", {127'd0, f_vout}, {127'd0, v});
            check("rt_inv_valid", {127'd0, i_vout}, {127'd0, v_prev});
            if (v_prev) check("rt_roundtrip", i_out, x_prev);
            if (v) begin
                x_prev = x;
            end
            v_prev = v;
        end

        // Reset mid-stream, asserted between edges
        use_chain = 1'b0;
        f_vin = 1'b1;
        f_in  = AppBIn;
        step();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out", f_out, '0);
        check("midrst_valid", {127'd0, f_vout}, 128'd0);
        check("midrst_inv_out", i_out, '0);
        @(negedge clock);
        reset_n = 1'b1;
        f_vin   = 1'b0;
        step();
        check("post_rst_valid", {127'd0, f_vout}, 128'd0);
        check("post_rst_out", f_out, '0);
        f_vin = 1'b1;
        f_in  = IdxIn;
        step();
        check("post_rst_first_valid", {127'd0, f_vout}, 128'd1);
        check("post_rst_first_out", f_out, IdxFwd);
        f_vin = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
